// File: rtl/riscv_run_monitor_if.sv
// rtl/riscv_run_monitor_if.sv - core-under-test observation and control bundle for riscv_run_monitor.
interface riscv_run_monitor_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      instr;
  logic [31:0]      pc;
  logic             core_rst;
  logic             running;
  logic [CNT_W-1:0] cycle_cnt;
  logic             done;
  logic             timeout;
  logic [31:0]      signature;

  modport master (
    output instr, pc,
    input  core_rst, running, cycle_cnt, done, timeout, signature
  );

  modport slave (
    input  instr, pc,
    output core_rst, running, cycle_cnt, done, timeout, signature
  );
endinterface

// File: rtl/riscv_run_monitor.sv
// rtl/riscv_run_monitor.sv - holds a core in reset, runs it, flags halt-loop completion or timeout.
// Optional PC signature accumulation enabled by macro RUN_MONITOR_SIG_EN.
module riscv_run_monitor #(
  parameter int          RST_CYCLES     = 2,
  parameter int          TIMEOUT_CYCLES = 30,
  parameter int          CNT_W          = 16,
  parameter logic [31:0] HALT_INSTR     = 32'h0000006F,
  parameter int          HALT_REPEAT    = 4
) (
  input logic               clk,
  input logic               rst,
  riscv_run_monitor_if.slave mon
);

  localparam int HOLD_W = (RST_CYCLES < 1) ? 1 : $clog2(RST_CYCLES + 1);
  localparam int HALT_W = (HALT_REPEAT < 2) ? 1 : $clog2(HALT_REPEAT + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES);
  localparam logic [HALT_W-1:0] HALT_LAST = HALT_W'(HALT_REPEAT - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RESET,
    S_HOLD,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HALT_W-1:0] halt_q, halt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       sig_q, sig_d;
  logic              core_rst_q, running_q, done_q, timeout_q;
  logic              halt_hit;

  assign halt_hit = (mon.instr == HALT_INSTR);

`ifndef RUN_MONITOR_SIG_EN
  logic unused_pc;
  assign unused_pc = ^mon.pc;
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    halt_d  = halt_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    case (state_q)
      S_RESET: begin
        if (RST_CYCLES == 0) begin
          state_d = S_RUN;
        end else begin
          state_d = S_HOLD;
        end
        hold_d = '0;
        halt_d = '0;
        cnt_d  = '0;
      end
      // The release edge enters HOLD; RST_CYCLES further HOLD edges follow before RUN.
      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
          halt_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RUN: begin
`ifdef RUN_MONITOR_SIG_EN
        sig_d = {sig_q[30:0], sig_q[31]} ^ mon.pc;
`endif
        if (halt_hit && (halt_q == HALT_LAST)) begin
          state_d = S_DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
          state_d = S_TIMEOUT;
        end else begin
          cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          halt_d = halt_hit ? halt_q + 1'b1 : '0;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RESET;
      hold_q     <= '0;
      halt_q     <= '0;
      cnt_q      <= '0;
      sig_q      <= '0;
      core_rst_q <= 1'b1;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      halt_q     <= halt_d;
      cnt_q      <= cnt_d;
      sig_q      <= sig_d;
      core_rst_q <= (state_d == S_RESET) || (state_d == S_HOLD);
      running_q  <= (state_d == S_RUN);
      done_q     <= (state_d == S_DONE);
      timeout_q  <= (state_d == S_TIMEOUT);
    end
  end

  assign mon.core_rst  = core_rst_q;
  assign mon.running   = running_q;
  assign mon.cycle_cnt = cnt_q;
  assign mon.done      = done_q;
  assign mon.timeout   = timeout_q;
  assign mon.signature = sig_q;

endmodule

// File: tb/tb_riscv_run_monitor.sv
// tb/tb_riscv_run_monitor.sv - directed self-checking bench for riscv_run_monitor.
module tb_riscv_run_monitor;

  localparam logic [31:0] HALT = 32'h0000006F;
  localparam logic [31:0] NOP  = 32'h00000013;
`ifdef RUN_MONITOR_SIG_EN
  localparam logic [31:0] SIG1 = 32'h00000004;
`else
  localparam logic [31:0] SIG1 = 32'h00000000;
`endif
  localparam logic [31:0] SIG2 = 32'h00000000;

  logic clk;
  logic rst;
  logic rst_b;
  int   checks;
  int   failures;

  riscv_run_monitor_if #(.CNT_W(16)) ifa ();
  riscv_run_monitor_if #(.CNT_W(16)) ifb ();

  riscv_run_monitor #(
    .RST_CYCLES(2), .TIMEOUT_CYCLES(30), .CNT_W(16),
    .HALT_INSTR(32'h0000006F), .HALT_REPEAT(4)
  ) dut_a (
    .clk(clk), .rst(rst), .mon(ifa)
  );

  riscv_run_monitor #(
    .RST_CYCLES(2), .TIMEOUT_CYCLES(0), .CNT_W(16),
    .HALT_INSTR(32'h0000006F), .HALT_REPEAT(4)
  ) dut_b (
    .clk(clk), .rst(rst_b), .mon(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic cr, input logic rn, input logic dn,
                       input logic to, input logic [31:0] cnt);
    chk({tag, ".core_rst"}, {31'd0, ifa.core_rst}, {31'd0, cr});
    chk({tag, ".running"}, {31'd0, ifa.running}, {31'd0, rn});
    chk({tag, ".done"}, {31'd0, ifa.done}, {31'd0, dn});
    chk({tag, ".timeout"}, {31'd0, ifa.timeout}, {31'd0, to});
    chk({tag, ".cycle_cnt"}, {16'd0, ifa.cycle_cnt}, cnt);
  endtask

  task automatic restart_a();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(4);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    rst_b     = 1'b1;
    ifa.instr = NOP;
    ifa.pc    = 32'h0;
    ifb.instr = NOP;
    ifb.pc    = 32'h0;
    tick(1);
    chk_a("reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("reset.signature", ifa.signature, 32'h0);

    // Release: three edges keep core_rst high, RUN on the fourth.
    rst   = 1'b0;
    rst_b = 1'b0;
    tick(1);
    chk_a("hold1", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(1);
    chk_a("hold2", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(1);
    chk_a("hold3", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(1);
    chk_a("run_entry", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

    ifa.pc = 32'h4;
    tick(1);
    chk("sig_pc4", ifa.signature, SIG1);
    chk("cnt_after_pc4", {16'd0, ifa.cycle_cnt}, 32'd1);
    ifa.pc = 32'h8;
    tick(1);
    chk("sig_pc8", ifa.signature, SIG2);
    ifa.pc = 32'h0;

    // Three halts, a NOP breaks the run, then four fresh halts complete.
    ifa.instr = HALT;
    tick(3);
    ifa.instr = NOP;
    tick(1);
    chk_a("halt_broken", 1'b0, 1'b1, 1'b0, 1'b0, 32'd6);
    ifa.instr = HALT;
    tick(3);
    chk_a("halt_restart3", 1'b0, 1'b1, 1'b0, 1'b0, 32'd9);
    tick(1);
    chk_a("halt_restart4", 1'b0, 1'b0, 1'b1, 1'b0, 32'd9);
    ifa.instr = NOP;
    tick(3);
    chk_a("done_absorbing", 1'b0, 1'b0, 1'b1, 1'b0, 32'd9);

    // Halt run starting at cycle_cnt=5 freezes the count at 8.
    restart_a();
    chk_a("run2_entry", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    tick(5);
    ifa.instr = HALT;
    tick(3);
    chk_a("halt3_of4", 1'b0, 1'b1, 1'b0, 1'b0, 32'd8);
    tick(1);
    chk_a("halt_done", 1'b0, 1'b0, 1'b1, 1'b0, 32'd8);
    ifa.instr = NOP;

    // Timeout on the cycle where cycle_cnt == 29.
    restart_a();
    tick(29);
    chk_a("pre_timeout", 1'b0, 1'b1, 1'b0, 1'b0, 32'd29);
    tick(1);
    chk_a("timeout", 1'b0, 1'b0, 1'b0, 1'b1, 32'd29);
    ifa.instr = HALT;
    tick(5);
    chk_a("timeout_absorbing", 1'b0, 1'b0, 1'b0, 1'b1, 32'd29);
    ifa.instr = NOP;

    // Halt completion coinciding with the timeout cycle wins.
    restart_a();
    tick(26);
    ifa.instr = HALT;
    tick(3);
    chk_a("coincide_pre", 1'b0, 1'b1, 1'b0, 1'b0, 32'd29);
    tick(1);
    chk_a("coincide", 1'b0, 1'b0, 1'b1, 1'b0, 32'd29);
    ifa.instr = NOP;

    // Reset mid-RUN at cycle 10, then the full hold sequence repeats.
    restart_a();
    tick(10);
    chk_a("mid_run", 1'b0, 1'b1, 1'b0, 1'b0, 32'd10);
    rst = 1'b1;
    tick(1);
    chk_a("mid_run_rst", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("mid_run_rst.signature", ifa.signature, 32'h0);
    rst = 1'b0;
    tick(3);
    chk_a("rehold3", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    tick(1);
    chk_a("rerun", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

    // TIMEOUT_CYCLES=0 instance never times out and saturates.
    chk("no_timeout_b", {31'd0, ifb.timeout}, 32'd0);
    tick(66000);
    chk("sat_cnt_b", {16'd0, ifb.cycle_cnt}, 32'h0000FFFF);
    chk("sat_running_b", {31'd0, ifb.running}, 32'd1);
    chk("sat_timeout_b", {31'd0, ifb.timeout}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
